i2c_master_ctrl: RTL and testbench

- Byte-level I2C master sequencer. Sits directly upstream of the SCL clock generator in the I2C core.
- Drives the generator's clock enable and watches the SCL it produces. Drives SDA open-drain.
- Executes one single-byte transaction per command: START, 7-bit address + R/W, ACK, one data byte (write) or one data byte with master NACK (read), STOP.
- Reports completion, read data and slave ACK error to the host side.

---
 rtl/i2c_master_ctrl.sv | 265 ++++++++++++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: byte-level I2C master sequencer.
// Runs one transaction per command: START, address + R/W, ACK, one data byte
// (write, slave ACK) or one data byte with master NACK (read), STOP.
// SCL comes from an external clock generator enabled through clk_en_o; SDA is
// driven open-drain through sda_oe_o.
// Optional read path: define I2C_MASTER_READ_EN. Without it the R/W bit is
// always 0, rw_i is ignored and rdata_o is tied to 0.
module i2c_master_ctrl #(
    parameter int DIVIDE_BY = 8
) (
    input  logic       i2c_core_clk_i,
    input  logic       reset_ni,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [6:0] addr_i,
    input  logic       rw_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] rdata_o,
    output logic       done_o,
    output logic       ack_err_o,
    output logic       busy_o,
    output logic       clk_en_o,
    input  logic       i2c_scl_i,
    output logic       sda_oe_o,
    input  logic       i2c_sda_i
);
    localparam int HALF = DIVIDE_BY / 2;
    localparam int TW   = $clog2(DIVIDE_BY) + 1;
    localparam logic [TW-1:0] HALF_M1 = TW'(HALF - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_WDATA,
        S_WDATA_ACK,
`ifdef I2C_MASTER_READ_EN
        S_RDATA,
        S_RD_NACK,
`endif
        S_STOP,
        S_DONE
    } state_t;

    state_t        r_state;
    logic          r_scl_q;
    logic [2:0]    r_cnt;
    logic          r_last;
    logic [7:0]    r_shift;
    logic [7:0]    r_wdata;
    logic          r_nack;
    logic          r_err;
    logic [TW-1:0] r_timer;
    logic [1:0]    r_stop_ph;
    logic          r_cmd_ready;
    logic          r_done;
    logic          r_ack_err;
    logic          r_clk_en;
    logic          r_sda_oe;
    logic          w_fall;
    logic          w_rise;
    logic          w_rw_bit;

`ifdef I2C_MASTER_READ_EN
    logic          r_rw;
    logic [7:0]    r_rd_shift;
    logic [7:0]    r_rdata;
    assign w_rw_bit = rw_i;
    assign rdata_o  = r_rdata;
`else
    logic          w_unused_rw;
    assign w_unused_rw = rw_i;
    assign w_rw_bit    = 1'b0;
    assign rdata_o     = 8'h00;
`endif

    assign w_fall      = r_scl_q & ~i2c_scl_i;
    assign w_rise      = ~r_scl_q & i2c_scl_i;
    assign cmd_ready_o = r_cmd_ready;
    assign busy_o      = ~r_cmd_ready;
    assign done_o      = r_done;
    assign ack_err_o   = r_ack_err;
    assign clk_en_o    = r_clk_en;
    assign sda_oe_o    = r_sda_oe;

    // Sequencer: command accept, START/STOP timing, bit shifting, status
    always_ff @(posedge i2c_core_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state     <= S_IDLE;
            r_scl_q     <= 1'b1;
            r_cnt       <= 3'd0;
            r_last      <= 1'b0;
            r_shift     <= 8'h00;
            r_wdata     <= 8'h00;
            r_nack      <= 1'b0;
            r_err       <= 1'b0;
            r_timer     <= '0;
            r_stop_ph   <= 2'd0;
            r_cmd_ready <= 1'b1;
            r_done      <= 1'b0;
            r_ack_err   <= 1'b0;
            r_clk_en    <= 1'b0;
            r_sda_oe    <= 1'b0;
`ifdef I2C_MASTER_READ_EN
            r_rw        <= 1'b0;
            r_rd_shift  <= 8'h00;
            r_rdata     <= 8'h00;
`endif
        end else begin
            r_scl_q <= i2c_scl_i;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i && r_cmd_ready) begin
                        r_shift     <= {addr_i, w_rw_bit};
                        r_wdata     <= wdata_i;
`ifdef I2C_MASTER_READ_EN
                        r_rw        <= rw_i;
`endif
                        r_err       <= 1'b0;
                        r_timer     <= '0;
                        r_cmd_ready <= 1'b0;
                        // START condition: SDA pulled low while SCL is idle high
                        r_sda_oe    <= 1'b1;
                        r_state     <= S_START;
                    end
                end
                S_START: begin
                    if (r_timer == HALF_M1) begin
                        r_timer  <= '0;
                        r_clk_en <= 1'b1;
                        r_cnt    <= 3'd7;
                        r_last   <= 1'b0;
                        r_state  <= S_ADDR;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_ADDR: begin
                    if (w_fall) begin
                        if (r_last) begin
                            r_last   <= 1'b0;
                            r_sda_oe <= 1'b0;
                            r_state  <= S_ADDR_ACK;
                        end else begin
                            r_sda_oe <= ~r_shift[r_cnt];
                            if (r_cnt == 3'd0) r_last <= 1'b1;
                            else               r_cnt  <= r_cnt - 3'd1;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_rise) begin
                        r_nack <= i2c_sda_i;
                    end else if (w_fall) begin
                        if (r_nack) begin
                            r_err     <= 1'b1;
                            r_sda_oe  <= 1'b1;
                            r_stop_ph <= 2'd0;
                            r_state   <= S_STOP;
                        end
`ifdef I2C_MASTER_READ_EN
                        else if (r_rw) begin
                            r_sda_oe <= 1'b0;
                            r_cnt    <= 3'd7;
                            r_last   <= 1'b0;
                            r_state  <= S_RDATA;
                        end
`endif
                        else begin
                            r_sda_oe <= ~r_wdata[7];
                            r_cnt    <= 3'd6;
                            r_last   <= 1'b0;
                            r_state  <= S_WDATA;
                        end
                    end
                end
                S_WDATA: begin
                    if (w_fall) begin
                        if (r_last) begin
                            r_last   <= 1'b0;
                            r_sda_oe <= 1'b0;
                            r_state  <= S_WDATA_ACK;
                        end else begin
                            r_sda_oe <= ~r_wdata[r_cnt];
                            if (r_cnt == 3'd0) r_last <= 1'b1;
                            else               r_cnt  <= r_cnt - 3'd1;
                        end
                    end
                end
                S_WDATA_ACK: begin
                    if (w_rise) begin
                        r_nack <= i2c_sda_i;
                    end else if (w_fall) begin
                        if (r_nack) r_err <= 1'b1;
                        r_sda_oe  <= 1'b1;
                        r_stop_ph <= 2'd0;
                        r_state   <= S_STOP;
                    end
                end
`ifdef I2C_MASTER_READ_EN
                S_RDATA: begin
                    if (w_rise) begin
                        r_rd_shift <= {r_rd_shift[6:0], i2c_sda_i};
                        if (r_cnt == 3'd0) r_last <= 1'b1;
                        else               r_cnt  <= r_cnt - 3'd1;
                    end else if (w_fall && r_last) begin
                        // SDA stays released through the 9th clock: master NACK
                        r_last  <= 1'b0;
                        r_state <= S_RD_NACK;
                    end
                end
                S_RD_NACK: begin
                    if (w_fall) begin
                        r_sda_oe  <= 1'b1;
                        r_stop_ph <= 2'd0;
                        r_state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    case (r_stop_ph)
                        2'd0: begin
                            // Park SCL high, then SDA rises HALF cycles later
                            if (w_rise) begin
                                r_clk_en  <= 1'b0;
                                r_timer   <= '0;
                                r_stop_ph <= 2'd1;
                            end
                        end
                        2'd1: begin
                            if (r_timer == HALF_M1) begin
                                r_sda_oe  <= 1'b0;
                                r_timer   <= '0;
                                r_stop_ph <= 2'd2;
                            end else begin
                                r_timer <= r_timer + TW'(1);
                            end
                        end
                        default: begin
                            // Bus-free time before reporting completion
                            if (r_timer == HALF_M1) begin
                                r_timer   <= '0;
                                r_done    <= 1'b1;
                                r_ack_err <= r_err;
`ifdef I2C_MASTER_READ_EN
                                if (r_rw) r_rdata <= r_rd_shift;
`endif
                                r_state   <= S_DONE;
                            end else begin
                                r_timer <= r_timer + TW'(1);
                            end
                        end
                    endcase
                end
                S_DONE: begin
                    r_done      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: SCL generator and slave model around the DUT,
// with a transaction-level reference of the expected bus bits and status.
module tb_i2c_master_ctrl;
    localparam int DIV  = 8;
    localparam int HALF = DIV / 2;
`ifdef I2C_MASTER_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [6:0] addr = 7'h00;
    logic       rw = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       cmd_ready, done, ack_err, busy, clk_en, sda_oe;
    logic [7:0] rdata;
    logic       scl = 1'b1;
    logic       slave_pull = 1'b0;
    logic       sda;
    int         gcnt = 0;

    assign sda = ~(sda_oe | slave_pull);

    i2c_master_ctrl #(.DIVIDE_BY(DIV)) dut (
        .i2c_core_clk_i(clk),
        .reset_ni      (rst_n),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .addr_i        (addr),
        .rw_i          (rw),
        .wdata_i       (wdata),
        .rdata_o       (rdata),
        .done_o        (done),
        .ack_err_o     (ack_err),
        .busy_o        (busy),
        .clk_en_o      (clk_en),
        .i2c_scl_i     (scl),
        .sda_oe_o      (sda_oe),
        .i2c_sda_i     (sda)
    );

    always #5 clk = ~clk;

    // slave configuration and reference expectations
    logic       sl_aa = 1'b1, sl_ad = 1'b1;
    logic [7:0] sl_rb = 8'h00;
    bit         exp_q[$];
    logic       exp_err;
    logic [7:0] exp_rdata = 8'h00;
    int         exp_pulses;

    // bus monitor state
    logic samples [0:31];
    int   rise_cnt = 0, cyc = 0;
    int   t_start = 0, t_first_fall = 0, t_last_rise = 0, t_stop = 0;
    int   n_done = 0;
    logic first_fall = 1'b1;
    logic scl_prev = 1'b1, sda_prev = 1'b1;

    int checks = 0, errors = 0;

    // Slave decision for the bit sampled on rise number k of a transaction
    function automatic logic slave_bit(input int k);
        logic is_rd, a_ok;
        is_rd = samples[7];
        a_ok  = !samples[8];
        if (k == 9) return sl_aa;
        if (!a_ok) return 1'b0;
        if (is_rd && k >= 10 && k <= 17) return !sl_rb[3'(17 - k)];
        if (!is_rd && k == 18) return sl_ad;
        return 1'b0;
    endfunction

    // SCL clock generator plus slave SDA driver (changes only while SCL falls)
    always @(posedge clk) begin
        if (!clk_en) begin
            scl <= 1'b1;
            gcnt <= 0;
            slave_pull <= 1'b0;
        end else if (gcnt == HALF - 1) begin
            gcnt <= 0;
            scl <= ~scl;
            if (scl) slave_pull <= slave_bit(rise_cnt + 1);
        end else begin
            gcnt <= gcnt + 1;
        end
    end

    // Bus monitor: START/STOP detection, SDA samples on SCL rises
    always @(negedge clk) begin
        cyc <= cyc + 1;
        scl_prev <= scl;
        sda_prev <= sda;
        if (scl && scl_prev && sda_prev && !sda) begin
            rise_cnt <= 0;
            t_start <= cyc;
            first_fall <= 1'b0;
        end else if (!scl_prev && scl) begin
            if (rise_cnt < 32) samples[rise_cnt[4:0]] <= sda;
            rise_cnt <= rise_cnt + 1;
            t_last_rise <= cyc;
        end
        if (scl && scl_prev && !sda_prev && sda) t_stop <= cyc;
        if (scl_prev && !scl && !first_fall) begin
            t_first_fall <= cyc;
            first_fall <= 1'b1;
        end
        if (done) n_done <= n_done + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Reference: bits seen on SDA at each SCL rise, plus final status
    task automatic model(input logic [6:0] a, input logic r, input logic [7:0] d,
                         input logic aa, input logic ad, input logic [7:0] rb);
        logic rd_op;
        rd_op = r & READ_EN;
        sl_aa = aa;
        sl_ad = ad;
        sl_rb = rb;
        exp_q.delete();
        for (int i = 6; i >= 0; i--) exp_q.push_back(a[i]);
        exp_q.push_back(rd_op);
        exp_q.push_back(!aa);
        if (aa) begin
            for (int i = 7; i >= 0; i--) exp_q.push_back(rd_op ? rb[i] : d[i]);
            exp_q.push_back(rd_op ? 1'b1 : !ad);
        end
        exp_q.push_back(1'b0);
        exp_err = !aa || (!rd_op && !ad);
        if (rd_op && aa) exp_rdata = rb;
        exp_pulses = aa ? 18 : 9;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Compare the captured bus activity and status against the reference
    task automatic check_result(input string tag);
        logic [31:0] ov, ev;
        ov = '0;
        ev = '0;
        for (int i = 0; i < exp_q.size() && i < 32; i++) begin
            ov[i] = samples[i];
            ev[i] = exp_q[i];
        end
        chk({tag, ":ack_err"}, ack_err, exp_err);
        chk({tag, ":rdata"}, rdata, exp_rdata);
        chk({tag, ":n_rises"}, rise_cnt, exp_q.size());
        chk({tag, ":sda_bits"}, ov, ev);
        chk({tag, ":scl_pulses"}, rise_cnt - 1, exp_pulses);
        chk({tag, ":start_hold"}, (t_first_fall - t_start) >= HALF, 1);
        chk({tag, ":stop_setup"}, (t_stop - t_last_rise) >= HALF, 1);
    endtask

    task automatic do_txn(input string tag, input logic [6:0] a, input logic r,
                          input logic [7:0] d, input logic aa, input logic ad,
                          input logic [7:0] rb);
        bit ok;
        model(a, r, d, aa, ad, rb);
        wait_ready(ok);
        chk({tag, ":ready_wait"}, ok, 1);
        cmd_valid = 1'b1;
        addr = a;
        rw = r;
        wdata = d;
        step();
        cmd_valid = 1'b0;
        chk({tag, ":busy"}, busy, 1);
        wait_done(ok);
        chk({tag, ":done_seen"}, ok, 1);
        if (ok) begin
            check_result(tag);
            step();
            chk({tag, ":done_pulse"}, done, 0);
            chk({tag, ":ready_back"}, cmd_ready, 1);
        end
    endtask

    initial begin : main
        bit ok;
        int viol, nd;
        logic [6:0] ra;
        logic [7:0] rd, rrb;
        logic rr, raa, rad;

        #1 rst_n = 1'b0;
        step();
        step();
        chk("rst:ready", cmd_ready, 1);
        chk("rst:busy", busy, 0);
        chk("rst:clk_en", clk_en, 0);
        chk("rst:sda_oe", sda_oe, 0);
        chk("rst:done", done, 0);
        chk("rst:ack_err", ack_err, 0);
        chk("rst:rdata", rdata, 0);
        chk("rst:scl", scl, 1);
        rst_n = 1'b1;
        step();

        do_txn("wr50", 7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00);
        do_txn("nack3c", 7'h3C, 1'b0, 8'h77, 1'b0, 1'b1, 8'h00);
        do_txn("rd68", 7'h68, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C);
        do_txn("wr_dnack", 7'h12, 1'b0, 8'h0F, 1'b1, 1'b0, 8'h00);

        // back-to-back commands with cmd_valid held high
        model(7'h21, 1'b0, 8'h5A, 1'b1, 1'b1, 8'h00);
        wait_ready(ok);
        chk("b2b:ready_wait", ok, 1);
        cmd_valid = 1'b1;
        addr = 7'h21;
        rw = 1'b0;
        wdata = 8'h5A;
        step();
        chk("b2b:busy1", busy, 1);
        addr = 7'h22;
        wdata = 8'hC3;
        viol = 0;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (cmd_ready) viol++;
        end
        chk("b2b:done1", ok, 1);
        chk("b2b:ready_low", viol, 0);
        chk("b2b:ready_at_done", cmd_ready, 0);
        check_result("b2b1");
        model(7'h22, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h00);
        step();
        chk("b2b:ready_after_done", cmd_ready, 1);
        chk("b2b:done_low", done, 0);
        step();
        chk("b2b:busy2", busy, 1);
        cmd_valid = 1'b0;
        wait_done(ok);
        chk("b2b:done2", ok, 1);
        if (ok) check_result("b2b2");
        step();

        // randomized transactions
        for (int it = 0; it < 6; it++) begin
            ra  = 7'($urandom_range(0, 127));
            rr  = 1'($urandom_range(0, 1));
            rd  = 8'($urandom_range(0, 255));
            rrb = 8'($urandom_range(0, 255));
            raa = ($urandom_range(0, 3) != 0) || rr;
            rad = 1'($urandom_range(0, 1));
            do_txn($sformatf("rnd%0d", it), ra, rr, rd, raa, rad, rrb);
        end

        // reset during data bit 4 of a write
        model(7'h50, 1'b0, 8'hFF, 1'b1, 1'b1, 8'h00);
        wait_ready(ok);
        cmd_valid = 1'b1;
        addr = 7'h50;
        rw = 1'b0;
        wdata = 8'hFF;
        step();
        cmd_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (rise_cnt == 13) begin
                ok = 1'b1;
                break;
            end
        end
        chk("mrst:reach_bit4", ok, 1);
        nd = n_done;
        rst_n = 1'b0;
        #1;
        chk("mrst:sda_oe", sda_oe, 0);
        chk("mrst:clk_en", clk_en, 0);
        chk("mrst:ready", cmd_ready, 1);
        exp_rdata = 8'h00;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("mrst:no_done", n_done, nd);
        chk("mrst:scl_high", scl, 1);
        do_txn("post_rst", 7'h50, 1'b0, 8'h11, 1'b1, 1'b1, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
